// File: rtl/nmi_irq_ctrl_pkg.sv
// Shared register map, id width and helpers for the NMI-bus interrupt controller.
package nmi_irq_ctrl_pkg;

    localparam int SRC_MAX        = 32;
    localparam int ID_WIDTH       = $clog2(SRC_MAX + 1);
    localparam int PRIO_WIDTH_DEF = 3;

    typedef logic [PRIO_WIDTH_DEF-1:0] prio_t;

    localparam logic [7:0] REG_ENABLE    = 8'h00;
    localparam logic [7:0] REG_MODE      = 8'h04;
    localparam logic [7:0] REG_PENDING   = 8'h08;
    localparam logic [7:0] REG_THRESHOLD = 8'h0C;
    localparam logic [7:0] REG_CLAIM     = 8'h10;
    localparam logic [7:0] REG_PRIO_BASE = 8'h80;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        for (int b = 0; b < 4; b++) begin
            strb_mask[8*b +: 8] = {8{strb[b]}};
        end
    endfunction

endpackage

// File: rtl/nmi_irq_ctrl_arb.sv
// Combinational arbiter: highest priority candidate wins, ties go to the lowest index.
module nmi_irq_ctrl_arb
    import nmi_irq_ctrl_pkg::*;
#(
    parameter int SRC_NUM    = 32,
    parameter int PRIO_WIDTH = 3
)(
    input  logic [SRC_NUM-1:0]            cand_i,
    input  logic [SRC_NUM*PRIO_WIDTH-1:0] prio_i,
    output logic [ID_WIDTH-1:0]           id_o,
    output logic [PRIO_WIDTH-1:0]         prio_o
);

    // Strict compare while scanning upward keeps the lowest index on ties.
    always_comb begin
        id_o   = '0;
        prio_o = '0;
        for (int i = 0; i < SRC_NUM; i++) begin
            if (cand_i[i] && (prio_i[i*PRIO_WIDTH +: PRIO_WIDTH] > prio_o)) begin
                id_o   = ID_WIDTH'(i + 1);
                prio_o = prio_i[i*PRIO_WIDTH +: PRIO_WIDTH];
            end
        end
    end

endmodule

// File: rtl/nmi_irq_ctrl.sv
// Interrupt controller on the NMI bus: sync, edge/level pending, enable, priority,
// threshold and claim/complete, with registered irq vector and arbitrated ext_irq.
module nmi_irq_ctrl
    import nmi_irq_ctrl_pkg::*;
#(
    parameter int SRC_NUM     = 32,
    parameter int PRIO_WIDTH  = 3,
    parameter int SYNC_STAGES = 2
)(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [SRC_NUM-1:0] irq_src_i,
    input  logic               nmi_valid_i,
    output logic               nmi_ready_o,
    input  logic [7:0]         nmi_addr_i,
    input  logic [31:0]        nmi_wdata_i,
    input  logic [3:0]         nmi_wstrb_i,
    output logic [31:0]        nmi_rdata_o,
    output logic [SRC_NUM-1:0] irq_o,
    output logic               ext_irq_o
);

    logic [SRC_NUM-1:0]            sync_q [SYNC_STAGES];
    logic [SRC_NUM-1:0]            sync_dly_q, sync_out, edge_det;
    logic [SRC_NUM-1:0]            enable_q, enable_d, mode_q, mode_d;
    logic [SRC_NUM-1:0]            pending_q, pending_d, in_srv_q, in_srv_d;
    logic [SRC_NUM-1:0]            w1c, claim_clr, pend_clr, prio_nz, cand;
    logic [SRC_NUM*PRIO_WIDTH-1:0] prio_q, prio_d;
    logic [PRIO_WIDTH-1:0]         thr_q, thr_d, win_prio;
    logic [ID_WIDTH-1:0]           claim_id_q, win_id, claim_val;
    logic [SRC_NUM-1:0]            irq_q;
    logic                          ext_q, ready_q;
    logic [31:0]                   rdata_q, rdata_d, mask;
    logic                          access, wr, rd, prio_sel;
    logic [5:0]                    word;
    logic [4:0]                    prio_idx;
    logic                          unused_addr;

    assign access      = nmi_valid_i && !ready_q;
    assign wr          = access && (nmi_wstrb_i != 4'd0);
    assign rd          = access && (nmi_wstrb_i == 4'd0);
    assign word        = nmi_addr_i[7:2];
    assign prio_idx    = nmi_addr_i[6:2];
    assign prio_sel    = nmi_addr_i[7] && (int'(prio_idx) < SRC_NUM);
    assign mask        = strb_mask(nmi_wstrb_i);
    assign unused_addr = ^nmi_addr_i[1:0];

    assign sync_out  = sync_q[SYNC_STAGES-1];
    assign edge_det  = sync_out & ~sync_dly_q;
    assign claim_val = ext_q ? claim_id_q : '0;

    always_comb begin
        rdata_d = '0;
        if (rd) begin
            if (prio_sel) begin
                rdata_d = 32'(prio_q[prio_idx*PRIO_WIDTH +: PRIO_WIDTH]);
            end else begin
                case (word)
                    REG_ENABLE[7:2]:    rdata_d = 32'(enable_q);
                    REG_MODE[7:2]:      rdata_d = 32'(mode_q);
                    REG_PENDING[7:2]:   rdata_d = 32'(pending_q);
                    REG_THRESHOLD[7:2]: rdata_d = 32'(thr_q);
                    REG_CLAIM[7:2]:     rdata_d = 32'(claim_val);
                    default:            rdata_d = '0;
                endcase
            end
        end
    end

    always_comb begin
        enable_d  = enable_q;
        mode_d    = mode_q;
        thr_d     = thr_q;
        prio_d    = prio_q;
        in_srv_d  = in_srv_q;
        w1c       = '0;
        claim_clr = '0;
        if (wr) begin
            if (prio_sel) begin
                prio_d[prio_idx*PRIO_WIDTH +: PRIO_WIDTH] = nmi_wdata_i[PRIO_WIDTH-1:0];
            end else begin
                case (word)
                    REG_ENABLE[7:2]: enable_d = (enable_q & ~mask[SRC_NUM-1:0])
                                              | (nmi_wdata_i[SRC_NUM-1:0] & mask[SRC_NUM-1:0]);
                    REG_MODE[7:2]:   mode_d   = (mode_q & ~mask[SRC_NUM-1:0])
                                              | (nmi_wdata_i[SRC_NUM-1:0] & mask[SRC_NUM-1:0]);
                    REG_PENDING[7:2]:   w1c   = nmi_wdata_i[SRC_NUM-1:0];
                    REG_THRESHOLD[7:2]: thr_d = nmi_wdata_i[PRIO_WIDTH-1:0];
                    REG_CLAIM[7:2]: begin
                        for (int i = 0; i < SRC_NUM; i++) begin
                            if (nmi_wdata_i == 32'(i + 1)) in_srv_d[i] = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (rd && !prio_sel && (word == REG_CLAIM[7:2])) begin
            for (int i = 0; i < SRC_NUM; i++) begin
                if (claim_val == ID_WIDTH'(i + 1)) begin
                    claim_clr[i] = 1'b1;
                    in_srv_d[i]  = 1'b1;
                end
            end
        end
    end

    // Edge bits: clear requests lose to a new edge; a level->edge switch drops the stale bit.
    assign pend_clr  = w1c | claim_clr | (mode_d & ~mode_q);
    assign pending_d = (mode_d & ((pending_q & ~pend_clr) | edge_det)) | (~mode_d & sync_out);

    always_comb begin
        prio_nz = '0;
        for (int i = 0; i < SRC_NUM; i++) begin
            prio_nz[i] = |prio_q[i*PRIO_WIDTH +: PRIO_WIDTH];
        end
    end

    assign cand = pending_q & enable_q & ~in_srv_q & prio_nz;

    nmi_irq_ctrl_arb #(
        .SRC_NUM    (SRC_NUM),
        .PRIO_WIDTH (PRIO_WIDTH)
    ) u_arb (
        .cand_i (cand),
        .prio_i (prio_q),
        .id_o   (win_id),
        .prio_o (win_prio)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            sync_dly_q <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            pending_q  <= '0;
            in_srv_q   <= '0;
            prio_q     <= '0;
            thr_q      <= '0;
            claim_id_q <= '0;
            irq_q      <= '0;
            ext_q      <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            sync_q[0] <= irq_src_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            sync_dly_q <= sync_out;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            pending_q  <= pending_d;
            in_srv_q   <= in_srv_d;
            prio_q     <= prio_d;
            thr_q      <= thr_d;
            claim_id_q <= win_id;
            irq_q      <= pending_q & enable_q & ~in_srv_q;
            ext_q      <= (win_id != '0) && (win_prio > thr_q);
            ready_q    <= access;
            rdata_q    <= rdata_d;
        end
    end

    assign nmi_ready_o = ready_q;
    assign nmi_rdata_o = rdata_q;
    assign irq_o       = irq_q;
    assign ext_irq_o   = ext_q;

endmodule

// File: tb/tb_nmi_irq_ctrl.sv
// Scoreboard bench for nmi_irq_ctrl: expected read data queued at issue, checked at ack.
module tb_nmi_irq_ctrl;

    localparam int SRC_NUM     = 32;
    localparam int PRIO_WIDTH  = 3;
    localparam int SYNC_STAGES = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [SRC_NUM-1:0] src;
    logic               valid;
    logic               ready;
    logic [7:0]         addr;
    logic [31:0]        wdata;
    logic [3:0]         wstrb;
    logic [31:0]        rdata;
    logic [SRC_NUM-1:0] irq;
    logic               ext;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    nmi_irq_ctrl #(
        .SRC_NUM     (SRC_NUM),
        .PRIO_WIDTH  (PRIO_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .irq_src_i   (src),
        .nmi_valid_i (valid),
        .nmi_ready_o (ready),
        .nmi_addr_i  (addr),
        .nmi_wdata_i (wdata),
        .nmi_wstrb_i (wstrb),
        .nmi_rdata_o (rdata),
        .irq_o       (irq),
        .ext_irq_o   (ext)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] r);
        int n;
        @(posedge clk);
        #1;
        valid = 1'b1;
        addr  = a;
        wdata = d;
        wstrb = s;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready && n < 8);
        check("ack_latency", 32'(n), 32'd1);
        r = rdata;
        @(posedge clk);
        #1;
        check("ready_single_pulse", 32'(ready), 32'd0);
        valid = 1'b0;
        wstrb = 4'd0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
        logic [31:0] r;
        bus(a, d, s, r);
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] r;
        exp_q.push_back(exp);
        bus(a, 32'd0, 4'd0, r);
        check(tag, r, exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        src   = '0;
        valid = 1'b0;
        addr  = '0;
        wdata = '0;
        wstrb = '0;
        cyc(3);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_irq", irq, 32'd0);
        check("rst_ext", 32'(ext), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);

        // Reset values of every register
        rd("rst_enable", 8'h00, 32'd0);
        rd("rst_mode", 8'h04, 32'd0);
        rd("rst_pending", 8'h08, 32'd0);
        rd("rst_thr", 8'h0C, 32'd0);
        rd("rst_claim", 8'h10, 32'd0);
        rd("rst_prio0", 8'h80, 32'd0);
        rd("rst_prio31", 8'hFC, 32'd0);

        // Level source 3: latency, claim, complete with source still high
        wr(8'h00, 32'h8);
        wr(8'h8C, 32'd2);
        wr(8'h0C, 32'd0);
        @(posedge clk);
        #1;
        src[3] = 1'b1;
        cyc(SYNC_STAGES + 1);
        check("lvl_ext_early", 32'(ext), 32'd0);
        cyc(1);
        check("lvl_ext_on_time", 32'(ext), 32'd1);
        check("lvl_irq", irq, 32'h8);
        rd("lvl_claim", 8'h10, 32'd4);
        check("lvl_ext_after_claim", 32'(ext), 32'd0);
        check("lvl_irq_after_claim", irq, 32'd0);
        wr(8'h10, 32'd4);
        check("lvl_ext_after_complete", 32'(ext), 32'd1);
        src[3] = 1'b0;
        cyc(5);
        check("lvl_ext_released", 32'(ext), 32'd0);

        // Edge sources 1 and 5, equal priority
        wr(8'h04, 32'h22);
        wr(8'h00, 32'h22);
        wr(8'h84, 32'd5);
        wr(8'h94, 32'd5);
        @(posedge clk);
        #1;
        src[1] = 1'b1;
        src[5] = 1'b1;
        cyc(1);
        src[1] = 1'b0;
        src[5] = 1'b0;
        cyc(5);
        rd("edge_pending", 8'h08, 32'h22);
        rd("edge_claim_a", 8'h10, 32'd2);
        rd("edge_claim_b", 8'h10, 32'd6);
        rd("edge_claim_none", 8'h10, 32'd0);
        rd("edge_pending_cleared", 8'h08, 32'd0);
        wr(8'h10, 32'd2);
        wr(8'h10, 32'd6);
        cyc(2);
        check("edge_ext_idle", 32'(ext), 32'd0);

        // Source 7 at priority 1 against threshold
        wr(8'h04, 32'h0);
        wr(8'h00, 32'h80);
        wr(8'h9C, 32'd1);
        wr(8'h0C, 32'd1);
        src[7] = 1'b1;
        cyc(6);
        check("thr_ext_blocked", 32'(ext), 32'd0);
        check("thr_irq_vec", irq, 32'h80);
        wr(8'h0C, 32'd0);
        check("thr_ext_open", 32'(ext), 32'd1);
        src[7] = 1'b0;
        cyc(5);

        // Edge on source 2 coincident with its W1C
        wr(8'h04, 32'h4);
        wr(8'h00, 32'h4);
        @(posedge clk);
        #1;
        src[2] = 1'b1;
        cyc(2);
        valid = 1'b1;
        addr  = 8'h08;
        wdata = 32'h4;
        wstrb = 4'hF;
        cyc(1);
        check("setwins_ack", 32'(ready), 32'd1);
        cyc(1);
        valid = 1'b0;
        wstrb = 4'd0;
        rd("setwins_pending", 8'h08, 32'h4);
        wr(8'h08, 32'h4);
        rd("w1c_pending", 8'h08, 32'd0);

        // Ignored completes and unmapped write
        wr(8'h04, 32'h0);
        wr(8'h88, 32'd3);
        cyc(5);
        check("ign_ext_before", 32'(ext), 32'd1);
        rd("ign_claim", 8'h10, 32'd3);
        wr(8'h10, 32'd0);
        wr(8'h10, 32'(SRC_NUM + 1));
        wr(8'h40, 32'hFFFF_FFFF);
        cyc(2);
        check("ign_irq", irq, 32'd0);
        check("ign_ext", 32'(ext), 32'd0);
        rd("ign_unmapped", 8'h40, 32'd0);
        rd("ign_enable", 8'h00, 32'h4);
        rd("ign_thr", 8'h0C, 32'd0);
        wr(8'h10, 32'd3);
        check("cmp_ext", 32'(ext), 32'd1);
        check("cmp_irq", irq, 32'h4);
        wr(8'h00, 32'hFFFF_FFFF, 4'b0010);
        rd("strb_enable", 8'h00, 32'h0000_FF04);
        wr(8'h04, 32'h4);
        rd("mode_switch_pending", 8'h08, 32'd0);
        src[2] = 1'b0;
        cyc(4);

        // Reset in the middle of an access
        @(posedge clk);
        #1;
        valid = 1'b1;
        addr  = 8'h00;
        wstrb = 4'd0;
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("midrst_ready", 32'(ready), 32'd0);
        end
        check("midrst_irq", irq, 32'd0);
        check("midrst_ext", 32'(ext), 32'd0);
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b1;
        cyc(2);
        check("postrst_ready", 32'(ready), 32'd0);
        rd("postrst_enable", 8'h00, 32'd0);
        rd("postrst_mode", 8'h04, 32'd0);
        rd("postrst_pending", 8'h08, 32'd0);
        rd("postrst_prio2", 8'h88, 32'd0);
        rd("postrst_claim", 8'h10, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
